// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the reg_file_clr register file.
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Controller state: IDLE accepts writes, CLEAR sweeps zeros through the array.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : reg_file_pkg

// File: rtl/reg_file_clr_ctl.sv
// Clear-sweep controller for reg_file_clr: two-state FSM plus clear counter.
// The current state is exported on o_state so it can be observed directly.
module reg_file_clr_ctl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output state_e            o_state,
    output logic [ADDR_W-1:0] o_clr_cnt,
    output logic              o_clr_we,
    output logic              o_busy
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic              w_last;

    // The last entry of the sweep is the all-ones address (DEPTH-1).
    assign w_last = (r_clr_cnt == {ADDR_W{1'b1}});

    // State and counter registers; reset parks the FSM at the start of a sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state logic: a request in IDLE starts a sweep, the sweep ends after DEPTH writes.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (w_last) begin
                    w_state_nxt   = IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // The array is only zeroed when reset is released; reset alone leaves it untouched.
    assign o_clr_we  = (r_state == CLEAR) && rst;
    assign o_busy    = (r_state == CLEAR) || !rst;
    assign o_state   = r_state;
    assign o_clr_cnt = r_clr_cnt;

endmodule : reg_file_clr_ctl

// File: rtl/reg_file_clr.sv
// Two-read/one-write flip-flop register file with a hardware clear sweep.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
// Handshake: clr_req is a single-cycle pulse honoured only when busy=0; while
// busy=1 both we and clr_req are dropped (nothing is queued) and reads return 0.
module reg_file_clr
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_e            w_state;
    logic [ADDR_W-1:0] w_clr_cnt;
    logic              w_clr_we;
    logic              w_busy;
    logic              w_usr_we;
    logic              w_fwd1;
    logic              w_fwd2;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    reg_file_clr_ctl #(
        .ADDR_W (ADDR_W)
    ) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .o_state   (w_state),
        .o_clr_cnt (w_clr_cnt),
        .o_clr_we  (w_clr_we),
        .o_busy    (w_busy)
    );

    // A user write lands only in IDLE, out of reset, without a competing clear
    // request, and never on the hardwired zero entry.
    assign w_usr_we = (w_state == IDLE) && !w_busy && we && !clr_req &&
                      !(ZERO_REG && (waddr == '0));

`ifdef REG_FILE_BYPASS_EN
    assign w_fwd1 = w_usr_we && (waddr == raddr1);
    assign w_fwd2 = w_usr_we && (waddr == raddr2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // Single write port shared by the clear sweep and user writes; the sweep has priority.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_cnt] <= '0;
        end else if (w_usr_we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port 1: array value, optional forwarding, zero entry and busy masking.
    always_comb begin
        w_rdata1 = r_mem[raddr1];
        if (w_fwd1) begin
            w_rdata1 = wdata;
        end
        if (ZERO_REG && (raddr1 == '0)) begin
            w_rdata1 = '0;
        end
        if (w_busy) begin
            w_rdata1 = '0;
        end
    end

    // Read port 2: identical to port 1 and fully independent of it.
    always_comb begin
        w_rdata2 = r_mem[raddr2];
        if (w_fwd2) begin
            w_rdata2 = wdata;
        end
        if (ZERO_REG && (raddr2 == '0)) begin
            w_rdata2 = '0;
        end
        if (w_busy) begin
            w_rdata2 = '0;
        end
    end

    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;
    assign busy   = w_busy;

endmodule : reg_file_clr
